// File: rtl/sng_stream.sv
// sng_stream: stochastic number generator stage.
// Converts a latched unsigned operand into a unipolar bitstream of
// STREAM_LEN bits. Each bit is (rnd < value), so the fraction of 1s is
// value / 2^WIDTH. The operand and the bitstream both use valid/ready
// handshakes.
// Optional feature: define SNG_ONES_COUNT_EN to build the ones counter,
// which reports the number of 1s in each completed stream.
module sng_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STREAM_LEN = 256,
  localparam int unsigned IDX_W     = $clog2(STREAM_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy,
  output logic [IDX_W:0]   ones_count,
  output logic             ones_valid
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STREAM_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_value;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_bit;
  logic             r_out_valid;

  logic w_accept;
  logic w_handshake;
  logic w_last;

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_handshake = (r_state == S_RUN) && r_out_valid && out_ready;
  assign w_last      = (r_idx == LAST_IDX);

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_last  = r_out_valid && w_last;

  // Stream sequencing: latch operand on accept, emit one bit per handshake.
  // rnd is sampled only on accept and handshake edges; stalls hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_value     <= '0;
      r_idx       <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_value     <= in_value;
      r_idx       <= '0;
      r_out_bit   <= (rnd < in_value);
      r_out_valid <= 1'b1;
      r_state     <= S_RUN;
    end else if (w_handshake) begin
      if (w_last) begin
        r_out_valid <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        r_idx     <= r_idx + IDX_ONE;
        r_out_bit <= (rnd < r_value);
      end
    end
  end

`ifdef SNG_ONES_COUNT_EN
  localparam logic [IDX_W:0] ACC_ONE = (IDX_W + 1)'(1);

  logic [IDX_W:0] r_acc;
  logic [IDX_W:0] r_ones_count;
  logic           r_ones_valid;

  // Count emitted 1s; the final bit is folded in directly when publishing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_ones_count <= '0;
      r_ones_valid <= 1'b0;
    end else begin
      r_ones_valid <= 1'b0;
      if (w_accept) begin
        r_acc <= '0;
      end else if (w_handshake) begin
        if (w_last) begin
          r_ones_count <= r_acc + (r_out_bit ? ACC_ONE : '0);
          r_ones_valid <= 1'b1;
        end else if (r_out_bit) begin
          r_acc <= r_acc + ACC_ONE;
        end
      end
    end
  end

  assign ones_count = r_ones_count;
  assign ones_valid = r_ones_valid;
`else
  assign ones_count = '0;
  assign ones_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sng_stream.sv
// Directed bench for sng_stream (WIDTH=8, STREAM_LEN=256).
// Expectations on ones_count/ones_valid follow SNG_ONES_COUNT_EN.
module tb_sng_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_value;
  logic [7:0] rnd;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic       busy;
  logic [8:0] ones_count;
  logic       ones_valid;

  int total = 0;
  int bad   = 0;

`ifdef SNG_ONES_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Observations collected by run_stream
  int         o_hs, o_ones, o_bit_err, o_last_err, o_stall_err, o_run_err, o_pulses;
  logic       o_rdy_after, o_ov2, o_ob2;
  logic [8:0] o_cnt, o_cnt2;

  sng_stream #(.WIDTH(8), .STREAM_LEN(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .rnd        (rnd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_last   (out_last),
    .busy       (busy),
    .ones_count (ones_count),
    .ones_valid (ones_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] exp_cnt(input int v);
    return CNT_EN ? 9'(v) : 9'd0;
  endfunction

  function automatic int exp_pulses();
    return CNT_EN ? 1 : 0;
  endfunction

  // Drives one stream with a ramp on rnd that advances per sample edge.
  // Inputs change on negedge; outputs are observed on negedge.
  task automatic run_stream(input logic [7:0] v, input bit stall, input bit hold);
    int   cyc;
    bit   prev_stall;
    logic pb, pl, ov, ob, ol, rd;
    o_hs = 0; o_ones = 0; o_bit_err = 0; o_last_err = 0;
    o_stall_err = 0; o_run_err = 0; o_pulses = 0;
    @(negedge clk);
    in_valid = 1'b1; in_value = v; rnd = 8'd0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = hold;
    in_value = hold ? 8'd200 : 8'd0;
    prev_stall = 1'b0; pb = 1'b0; pl = 1'b0; cyc = 0;
    while (o_hs < 256 && cyc < 2000) begin
      ov = out_valid; ob = out_bit; ol = out_last;
      if (ov !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) o_run_err++;
      else begin
        if (ob !== (o_hs < int'(v))) o_bit_err++;
        if (ol !== (o_hs == 255)) o_last_err++;
        if (prev_stall && (ob !== pb || ol !== pl)) o_stall_err++;
      end
      o_pulses += int'(ones_valid);
      rd = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rd;
      rnd = 8'(o_hs + 1);
      prev_stall = ov && !rd; pb = ob; pl = ol;
      @(negedge clk);
      cyc++;
      if (ov === 1'b1 && rd) begin
        o_hs++;
        if (ob === 1'b1) o_ones++;
      end
    end
    o_rdy_after = in_ready;
    o_cnt = ones_count;
    o_pulses += int'(ones_valid);
    out_ready = 1'b0;
    rnd = 8'd150;
    @(negedge clk);
    o_ov2 = out_valid;
    o_ob2 = out_bit;
    o_cnt2 = ones_count;
    o_pulses += int'(ones_valid);
    in_valid = 1'b0;
    in_value = 8'd0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL reset_out_bit got=%b want=0", out_bit); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ones_count !== 9'd0) begin bad++; $display("FAIL reset_ones_count got=%0d want=0", ones_count); end
    total++; if (ones_valid !== 1'b0) begin bad++; $display("FAIL reset_ones_valid got=%b want=0", ones_valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    run_stream(8'd64, 1'b0, 1'b0);
    total++; if (o_hs !== 256) begin bad++; $display("FAIL ramp_handshakes got=%0d want=256", o_hs); end
    total++; if (o_ones !== 64) begin bad++; $display("FAIL ramp_ones got=%0d want=64", o_ones); end
    total++; if (o_bit_err !== 0) begin bad++; $display("FAIL ramp_bit_pattern errors=%0d want=0", o_bit_err); end
    total++; if (o_last_err !== 0) begin bad++; $display("FAIL ramp_out_last errors=%0d want=0", o_last_err); end
    total++; if (o_run_err !== 0) begin bad++; $display("FAIL ramp_run_flags errors=%0d want=0", o_run_err); end
    total++; if (o_rdy_after !== 1'b1) begin bad++; $display("FAIL ramp_in_ready_after got=%b want=1", o_rdy_after); end
    total++; if (o_cnt !== exp_cnt(64)) begin bad++; $display("FAIL ramp_ones_count got=%0d want=%0d", o_cnt, exp_cnt(64)); end
    total++; if (o_pulses !== exp_pulses()) begin bad++; $display("FAIL ramp_ones_valid_pulses got=%0d want=%0d", o_pulses, exp_pulses()); end
    total++; if (o_cnt2 !== exp_cnt(64)) begin bad++; $display("FAIL ramp_ones_count_hold got=%0d want=%0d", o_cnt2, exp_cnt(64)); end
    total++; if (o_ov2 !== 1'b0) begin bad++; $display("FAIL ramp_idle_out_valid got=%b want=0", o_ov2); end
  endtask

  task automatic test_boundary();
    run_stream(8'd0, 1'b0, 1'b0);
    total++; if (o_ones !== 0) begin bad++; $display("FAIL zero_ones got=%0d want=0", o_ones); end
    total++; if (o_cnt !== 9'd0) begin bad++; $display("FAIL zero_ones_count got=%0d want=0", o_cnt); end
    total++; if (o_pulses !== exp_pulses()) begin bad++; $display("FAIL zero_pulses got=%0d want=%0d", o_pulses, exp_pulses()); end
    run_stream(8'd255, 1'b0, 1'b0);
    total++; if (o_ones !== 255) begin bad++; $display("FAIL full_ones got=%0d want=255", o_ones); end
    total++; if (o_bit_err !== 0) begin bad++; $display("FAIL full_bit_pattern errors=%0d want=0", o_bit_err); end
    total++; if (o_cnt !== exp_cnt(255)) begin bad++; $display("FAIL full_ones_count got=%0d want=%0d", o_cnt, exp_cnt(255)); end
  endtask

  task automatic test_back_pressure();
    run_stream(8'd128, 1'b1, 1'b0);
    total++; if (o_hs !== 256) begin bad++; $display("FAIL bp_handshakes got=%0d want=256", o_hs); end
    total++; if (o_stall_err !== 0) begin bad++; $display("FAIL bp_stall_stability errors=%0d want=0", o_stall_err); end
    total++; if (o_ones !== 128) begin bad++; $display("FAIL bp_ones got=%0d want=128", o_ones); end
    total++; if (o_bit_err !== 0) begin bad++; $display("FAIL bp_bit_pattern errors=%0d want=0", o_bit_err); end
    total++; if (o_last_err !== 0) begin bad++; $display("FAIL bp_out_last errors=%0d want=0", o_last_err); end
    total++; if (o_cnt !== exp_cnt(128)) begin bad++; $display("FAIL bp_ones_count got=%0d want=%0d", o_cnt, exp_cnt(128)); end
  endtask

  task automatic test_ignore_running();
    run_stream(8'd64, 1'b0, 1'b1);
    total++; if (o_run_err !== 0) begin bad++; $display("FAIL ign_in_ready_low errors=%0d want=0", o_run_err); end
    total++; if (o_ones !== 64) begin bad++; $display("FAIL ign_ones got=%0d want=64", o_ones); end
    total++; if (o_bit_err !== 0) begin bad++; $display("FAIL ign_bit_pattern errors=%0d want=0", o_bit_err); end
    total++; if (o_cnt !== exp_cnt(64)) begin bad++; $display("FAIL ign_ones_count got=%0d want=%0d", o_cnt, exp_cnt(64)); end
    // Second operand (200) accepted in the IDLE bubble with rnd=150 -> bit 1
    total++; if (o_ov2 !== 1'b1) begin bad++; $display("FAIL ign_second_accept got=%b want=1", o_ov2); end
    total++; if (o_ob2 !== 1'b1) begin bad++; $display("FAIL ign_second_first_bit got=%b want=1", o_ob2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_value = 8'd64; rnd = 8'd0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) begin
      rnd = rnd + 8'd1;
      @(negedge clk);
    end
    total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_running got=%b%b want=11", out_valid, busy); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
    total++; if (ones_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_ones_valid got=%b want=0", ones_valid); end
    total++; if (ones_count !== 9'd0) begin bad++; $display("FAIL mid_rst_ones_count got=%0d want=0", ones_count); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL mid_rst_out_last got=%b want=0", out_last); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    run_stream(8'd32, 1'b0, 1'b0);
    total++; if (o_ones !== 32) begin bad++; $display("FAIL mid_after_ones got=%0d want=32", o_ones); end
    total++; if (o_cnt !== exp_cnt(32)) begin bad++; $display("FAIL mid_after_ones_count got=%0d want=%0d", o_cnt, exp_cnt(32)); end
    total++; if (o_pulses !== exp_pulses()) begin bad++; $display("FAIL mid_after_pulses got=%0d want=%0d", o_pulses, exp_pulses()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = 8'd0; rnd = 8'd0; out_ready = 1'b0;
    test_reset();
    test_ramp();
    test_boundary();
    test_back_pressure();
    test_ignore_running();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sng_stream.md
# sng_stream

Stochastic number generator stage that converts an unsigned binary operand into a unipolar stochastic bitstream of fixed length. Sits directly downstream of the 8-bit LFSR random source: on each emitted bit it compares the LFSR value against the latched operand, emitting 1 when `rnd < value`. Operand input and bitstream output both use valid/ready handshakes, so the block can feed stochastic arithmetic stages that may stall.

## Interface
- `WIDTH`, 8: operand and random-source width.
- `STREAM_LEN`, 256: bits per stream; must be at least 2. `IDX_W = $clog2(STREAM_LEN)`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  block can accept an operand; equals (state == IDLE).
- `in_value`  in  WIDTH  unsigned operand; probability is `in_value / 2^WIDTH`.
- `rnd`  in  WIDTH  random sample, normally the LFSR output.
- `out_valid`  out  1  `out_bit` is valid.
- `out_ready`  in  1  downstream accepts `out_bit`.
- `out_bit`  out  1  stochastic bit.
- `out_last`  out  1  high with the final bit of a stream: `out_valid && idx == STREAM_LEN-1`.
- `busy`  out  1  equals (state == RUN).
- `ones_count`  out  IDX_W+1  number of 1s in the completed stream. This port is 0 when the feature is not compiled in.
- `ones_valid`  out  1  one-cycle pulse when `ones_count` updates. This port is 0 when the feature is not compiled in.

## Operation
- **States:** IDLE and RUN.
- **Registers:** `value_reg` (WIDTH), `idx` (IDX_W), `out_bit`, `out_valid`, and, if the feature is compiled in, `acc` and `ones_count`.
- **Reset:** Every register clears to 0 and the state goes to IDLE. Resulting outputs: `in_ready`=1, `out_valid`=0, `out_bit`=0, `out_last`=0, `busy`=0, `ones_count`=0, `ones_valid`=0.
- **IDLE, when `in_valid` is high:**
  - `value_reg <= in_value`, `idx <= 0`.
  - `out_bit <= (rnd < in_value)`, using an unsigned WIDTH-bit compare.
  - `out_valid <= 1`, state goes to RUN.
- **RUN, when `out_valid && out_ready` is high (handshake):**
  - If `idx == STREAM_LEN-1`: `out_valid <= 0`, state goes to IDLE.
  - Otherwise: `idx <= idx+1`, `out_bit <= (rnd < value_reg)`.
- **RUN, when the handshake does not occur:** all registers hold. `out_bit` stays stable and `rnd` is not sampled.
- **`in_valid` during RUN:** ignored; `in_ready` is 0.
- **Boundary values:**
  - `value` = 0 gives an all-zero stream.
  - `value` = 2^WIDTH-1 gives a 1 whenever `rnd` is not all-ones.
  - No overflow can occur. The compare is strictly less-than.

## Timing
- Latency from operand accept to first bit: 1 cycle (`out_valid` rises on the edge after the accept).
- Throughput: one bit per cycle while `out_ready` is held high.
- `rnd` is sampled only on the accept edge and on handshake edges.
- There is one IDLE bubble cycle between streams. A stream therefore occupies STREAM_LEN+1 cycles minimum, from accept through the cycle in which `in_ready` returns high.
- `out_last` is combinational from registers and has no input-to-output path.
- `in_ready` and `busy` are decoded from the state register.
- Reset asserted mid-stream: all outputs go to their reset values immediately (asynchronous). No partial `ones_valid` pulse is produced. After `rst` falls, the first possible accept is the next rising edge.

## Configuration
- Macro: `SNG_ONES_COUNT_EN`.
- **With `SNG_ONES_COUNT_EN` defined:**
  - `acc` (IDX_W+1 bits) clears on accept and increments on each handshake where `out_bit` = 1.
  - On the final handshake: `ones_count <= acc + out_bit` and `ones_valid <= 1` for exactly one cycle.
  - `ones_count` holds its value until the next stream completes or reset.
- **Without `SNG_ONES_COUNT_EN`:** no accumulator logic is built, and `ones_count` and `ones_valid` are tied to 0.

## Test plan
All scenarios use WIDTH=8 and STREAM_LEN=256, with the macro defined unless stated otherwise.
- **Ramp stimulus:** accept `in_value`=64 with `rnd` driven 0,1,…,255 (advancing per sample edge) and `out_ready`=1.
  - Exactly 64 ones, occurring on the first 64 bits.
  - `out_last` high only on bit 255.
  - `ones_count`=64 with a single `ones_valid` pulse.
  - `in_ready`=1 on the cycle after the last handshake.
- **Boundary values:** `in_value`=0 gives 0 ones and `ones_count`=0. `in_value`=255 with the same ramp gives 255 ones and `ones_count`=255.
- **Backpressure:** `in_value`=128 with `out_ready` toggling pseudo-randomly (about 50%).
  - `out_bit` and `out_last` stay stable while stalled.
  - Exactly 256 handshakes occur.
  - `ones_count`=128 with a ramp that advances only on handshakes.
- **Input ignored while running:** hold `in_valid`=1 with `in_value`=200 during RUN. `in_ready`=0 throughout, the stream still reflects the original operand, and the second operand is accepted only in IDLE.
- **Reset mid-stream:** assert `rst` after handshake 100. `out_valid`, `busy` and `ones_valid` go to 0 immediately and `in_ready`=1. A new stream of `in_value`=32 then completes with `ones_count`=32.
- **Macro off:** the ramp scenario with `in_value`=64 gives the identical bitstream, while `ones_count` and `ones_valid` stay at 0.
